arrow_scheduler: RTL and testbench
==================================

ARROW_SCHEDULER -- requirements
Module: arrow_scheduler

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 4, number of arrow instances managed.
REQ-002 SHALL have parameter LIFE_VERT, default 180, frames an arrow with direction 00/01/11 stays on screen.
REQ-003 SHALL have parameter LIFE_HORZ, default 256, frames an arrow with direction 10 stays on screen.
REQ-004 SHALL have parameters HIT_LO, default 150, and HIT_HI, default 175, the inclusive frame-age hit window, vertical directions only.
REQ-005 SHALL have parameters HIT_LO_H, default 220, and HIT_HI_H, default 250, the inclusive hit window for direction 10.
REQ-006 SHALL have: clk  input  1  system clock; all logic on rising edge.
REQ-007 SHALL have: rst_in  input  1  synchronous, active-high reset.
REQ-008 SHALL have: hcount_in  input  11  and  vcount_in  input  10, current raster position.
REQ-009 SHALL have: spawn_valid_in  input  1, spawn_ready_out  output  1, the spawn request handshake.
REQ-010 SHALL have: spawn_direction_in  input  2, spawn_speed_in  input  3, spawn_inversed_in  input  1, the spawn payload.
REQ-011 SHALL have: hit_valid_in  input  1  and  hit_direction_in  input  2, a player key press, one cycle.
REQ-012 SHALL have: slot_valid_out  output  NUM_SLOTS, and per-slot slot_direction_out (2b), slot_speed_out (3b), slot_inversed_out (1b), packed, driving arrow instances.
REQ-013 SHALL have: hit_out  output  1, miss_out  output  1, one-cycle result pulses.

Function
REQ-014 SHALL derive frame_tick = (hcount_in==0 && vcount_in==0), registered once so it is a single-cycle pulse per frame.
REQ-015 Each slot SHALL have states IDLE, ACTIVE, COOLDOWN.
REQ-016 Spawn transfer SHALL occur on a cycle where spawn_valid_in && spawn_ready_out; spawn_ready_out SHALL be high iff any slot is IDLE.
REQ-017 On transfer the lowest-index IDLE slot SHALL latch the payload, clear its age counter to 0 and enter ACTIVE; slot_valid_out[i] SHALL rise the next cycle.
REQ-018 Payload outputs of a slot SHALL be stable for its whole ACTIVE period.
REQ-019 Each ACTIVE slot SHALL increment an 8-bit age counter on frame_tick, saturating at 255.
REQ-020 An ACTIVE slot SHALL expire when age reaches its lifetime (LIFE_HORZ for direction 10, else LIFE_VERT): enter COOLDOWN, pulse miss_out one cycle.
REQ-021 On hit_valid_in, the ACTIVE slot with matching direction and age inside its hit window SHALL retire to COOLDOWN and hit_out SHALL pulse the next cycle.
REQ-022 Among multiple eligible slots the oldest (largest age) SHALL be retired; ties go to the lowest index; only one slot retires per press.
REQ-023 A press with no eligible slot SHALL produce neither hit_out nor miss_out and change no state.
REQ-024 COOLDOWN SHALL hold slot_valid_out[i] low exactly one cycle, then go IDLE, so the arrow sees a fresh rising edge on reuse.
REQ-025 A slot retiring in a cycle SHALL NOT be reused for a spawn in that same cycle; the spawn goes to another IDLE slot or stalls.
REQ-026 If expiry and hit target the same slot in one cycle, hit SHALL win: hit_out pulses, miss_out does not.
REQ-027 Expiries of several slots in one cycle SHALL produce one miss_out pulse per expiry, serialized in index order.
REQ-028 slot_valid_out[i] SHALL be 1 exactly in ACTIVE.

Reset
REQ-029 On rst_in all slots SHALL be IDLE, ages 0, slot_valid_out=0, payload outputs 0, hit_out=0, miss_out=0, spawn_ready_out=1 the cycle after reset deasserts.
REQ-030 Reset asserted mid-operation SHALL drop all slot_valid_out within one cycle and discard pending miss pulses.

Structure
REQ-031 Slot state enum, direction encodings (00 down, 01 up, 10 right, 11 down) and default lifetimes/windows SHALL live in shared package arrow_pkg.
REQ-032 Per-slot state, age and payload SHALL be one sub-module arrow_slot, instantiated NUM_SLOTS times; allocation, hit selection and miss serialization stay in arrow_scheduler.

Verification
REQ-033 Reset, then spawn dir 00 speed 2 -> slot 0 valid next cycle, ready stays 1, slot 0 direction 00, speed 2.
REQ-034 Spawn 4 arrows back-to-back -> slots 0..3 fill in order, spawn_ready_out=0, 5th request stalls until one slot completes COOLDOWN.
REQ-035 Dir 00 arrow, press dir 00 at age 160 -> hit_out one pulse, slot_valid_out[0] low 1 cycle then IDLE; press at age 100 -> no pulse.
REQ-036 Dir 10 arrow left alone -> miss_out at age 256, never hit_out.
REQ-037 Two dir 01 arrows, ages 170 and 155, one press -> only the age-170 slot retires.
REQ-038 Spawn in slots 0 and 1 same frame, no presses -> two miss_out pulses on consecutive cycles; rst_in mid-flight -> all valid low next cycle.

Source files
------------

// File: rtl/arrow_pkg.sv
// rtl/arrow_pkg.sv - shared slot state, direction encodings and default arrow timing
package arrow_pkg;

  typedef enum logic [1:0] {
    SLOT_IDLE     = 2'd0,
    SLOT_ACTIVE   = 2'd1,
    SLOT_COOLDOWN = 2'd2
  } slot_state_e;

  localparam logic [1:0] DIR_DOWN     = 2'b00;
  localparam logic [1:0] DIR_UP       = 2'b01;
  localparam logic [1:0] DIR_RIGHT    = 2'b10;
  localparam logic [1:0] DIR_DOWN_ALT = 2'b11;

  localparam int DEF_LIFE_VERT = 180;
  localparam int DEF_LIFE_HORZ = 256;
  localparam int DEF_HIT_LO    = 150;
  localparam int DEF_HIT_HI    = 175;
  localparam int DEF_HIT_LO_H  = 220;
  localparam int DEF_HIT_HI_H  = 250;

  function automatic logic in_window(input logic [7:0] age, input int lo, input int hi);
    return (int'(age) >= lo) && (int'(age) <= hi);
  endfunction

endpackage

// File: rtl/arrow_slot.sv
// rtl/arrow_slot.sv - one arrow instance: state, frame age and latched payload
module arrow_slot
  import arrow_pkg::*;
#(
  parameter int LIFE_VERT = DEF_LIFE_VERT,
  parameter int LIFE_HORZ = DEF_LIFE_HORZ
) (
  input  logic        clk,
  input  logic        rst_in,
  input  logic        frame_tick_in,
  input  logic        spawn_in,
  input  logic [1:0]  direction_in,
  input  logic [2:0]  speed_in,
  input  logic        inversed_in,
  input  logic        retire_in,
  output slot_state_e state_out,
  output logic [7:0]  age_out,
  output logic [1:0]  direction_out,
  output logic [2:0]  speed_out,
  output logic        inversed_out,
  output logic        expire_out
);

  slot_state_e state_q, state_d;
  logic [7:0]  age_q, age_d;
  logic [1:0]  direction_q, direction_d;
  logic [2:0]  speed_q, speed_d;
  logic        inversed_q, inversed_d;
  logic [8:0]  life;

  // Age is 8 bits but the horizontal lifetime is 256, so expiry compares the
  // would-be next age in 9 bits instead of the stored value.
  assign life       = (direction_q == DIR_RIGHT) ? 9'(LIFE_HORZ) : 9'(LIFE_VERT);
  assign expire_out = (state_q == SLOT_ACTIVE) && frame_tick_in &&
                      (({1'b0, age_q} + 9'd1) >= life);

  always_comb begin
    state_d     = state_q;
    age_d       = age_q;
    direction_d = direction_q;
    speed_d     = speed_q;
    inversed_d  = inversed_q;
    case (state_q)
      SLOT_IDLE: begin
        if (spawn_in) begin
          state_d     = SLOT_ACTIVE;
          age_d       = 8'd0;
          direction_d = direction_in;
          speed_d     = speed_in;
          inversed_d  = inversed_in;
        end
      end
      SLOT_ACTIVE: begin
        if (retire_in || expire_out) begin
          state_d = SLOT_COOLDOWN;
        end else if (frame_tick_in && (age_q != 8'hff)) begin
          age_d = age_q + 8'd1;
        end
      end
      default: state_d = SLOT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q     <= SLOT_IDLE;
      age_q       <= 8'd0;
      direction_q <= 2'd0;
      speed_q     <= 3'd0;
      inversed_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      age_q       <= age_d;
      direction_q <= direction_d;
      speed_q     <= speed_d;
      inversed_q  <= inversed_d;
    end
  end

  assign state_out     = state_q;
  assign age_out       = age_q;
  assign direction_out = direction_q;
  assign speed_out     = speed_q;
  assign inversed_out  = inversed_q;

endmodule

// File: rtl/arrow_scheduler.sv
// rtl/arrow_scheduler.sv - allocates arrow slots, judges key presses, serializes misses
module arrow_scheduler
  import arrow_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int LIFE_VERT = DEF_LIFE_VERT,
  parameter int LIFE_HORZ = DEF_LIFE_HORZ,
  parameter int HIT_LO    = DEF_HIT_LO,
  parameter int HIT_HI    = DEF_HIT_HI,
  parameter int HIT_LO_H  = DEF_HIT_LO_H,
  parameter int HIT_HI_H  = DEF_HIT_HI_H
) (
  input  logic                   clk,
  input  logic                   rst_in,
  input  logic [10:0]            hcount_in,
  input  logic [9:0]             vcount_in,
  input  logic                   spawn_valid_in,
  output logic                   spawn_ready_out,
  input  logic [1:0]             spawn_direction_in,
  input  logic [2:0]             spawn_speed_in,
  input  logic                   spawn_inversed_in,
  input  logic                   hit_valid_in,
  input  logic [1:0]             hit_direction_in,
  output logic [NUM_SLOTS-1:0]   slot_valid_out,
  output logic [2*NUM_SLOTS-1:0] slot_direction_out,
  output logic [3*NUM_SLOTS-1:0] slot_speed_out,
  output logic [NUM_SLOTS-1:0]   slot_inversed_out,
  output logic                   hit_out,
  output logic                   miss_out
);

  logic                 at_origin_q, at_origin_d;
  logic                 frame_tick_q, frame_tick_d;
  logic [NUM_SLOTS-1:0] pending_q, pending_d;
  logic                 hit_q, hit_d;
  logic                 miss_q, miss_d;

  slot_state_e          state_w [NUM_SLOTS];
  logic [7:0]           age_w   [NUM_SLOTS];
  logic [1:0]           dir_w   [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] expire_w;
  logic [NUM_SLOTS-1:0] spawn_sel;
  logic [NUM_SLOTS-1:0] retire_sel;
  logic [NUM_SLOTS-1:0] miss_all;
  logic                 any_idle;
  logic                 best_found;
  logic [7:0]           best_age;
  logic                 eligible;

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    arrow_slot #(
      .LIFE_VERT(LIFE_VERT),
      .LIFE_HORZ(LIFE_HORZ)
    ) u_slot (
      .clk          (clk),
      .rst_in       (rst_in),
      .frame_tick_in(frame_tick_q),
      .spawn_in     (spawn_sel[i]),
      .direction_in (spawn_direction_in),
      .speed_in     (spawn_speed_in),
      .inversed_in  (spawn_inversed_in),
      .retire_in    (retire_sel[i]),
      .state_out    (state_w[i]),
      .age_out      (age_w[i]),
      .direction_out(dir_w[i]),
      .speed_out    (slot_speed_out[3*i +: 3]),
      .inversed_out (slot_inversed_out[i]),
      .expire_out   (expire_w[i])
    );
    assign slot_valid_out[i]           = (state_w[i] == SLOT_ACTIVE);
    assign slot_direction_out[2*i +: 2] = dir_w[i];
  end

  // Retiring slots sit in COOLDOWN, never IDLE, so they cannot be re-picked here.
  always_comb begin
    spawn_sel = '0;
    any_idle  = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!any_idle && state_w[i] == SLOT_IDLE) begin
        spawn_sel[i] = spawn_valid_in;
        any_idle     = 1'b1;
      end
    end
  end

  assign spawn_ready_out = any_idle;

  always_comb begin
    retire_sel = '0;
    best_found = 1'b0;
    best_age   = 8'd0;
    eligible   = 1'b0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      eligible = hit_valid_in && (state_w[i] == SLOT_ACTIVE) &&
                 (dir_w[i] == hit_direction_in) &&
                 ((dir_w[i] == DIR_RIGHT) ? in_window(age_w[i], HIT_LO_H, HIT_HI_H)
                                          : in_window(age_w[i], HIT_LO, HIT_HI));
      if (eligible && (!best_found || age_w[i] > best_age)) begin
        retire_sel    = '0;
        retire_sel[i] = 1'b1;
        best_found    = 1'b1;
        best_age      = age_w[i];
      end
    end
  end

  // Pending misses drain lowest index first, one pulse per cycle.
  always_comb begin
    at_origin_d  = (hcount_in == 11'd0) && (vcount_in == 10'd0);
    frame_tick_d = at_origin_d && !at_origin_q;
    hit_d        = |retire_sel;
    miss_all     = pending_q | (expire_w & ~retire_sel);
    miss_d       = |miss_all;
    pending_d    = miss_all & (miss_all - 1'b1);
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      at_origin_q  <= 1'b0;
      frame_tick_q <= 1'b0;
      pending_q    <= '0;
      hit_q        <= 1'b0;
      miss_q       <= 1'b0;
    end else begin
      at_origin_q  <= at_origin_d;
      frame_tick_q <= frame_tick_d;
      pending_q    <= pending_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
    end
  end

  assign hit_out  = hit_q;
  assign miss_out = miss_q;

endmodule

// File: tb/tb_arrow_scheduler.sv
// tb/tb_arrow_scheduler.sv - directed self-checking bench for arrow_scheduler
module tb_arrow_scheduler;

  logic        clk = 1'b0;
  logic        rst_in = 1'b1;
  logic [10:0] hcount_in = 11'd5;
  logic [9:0]  vcount_in = 10'd5;
  logic        spawn_valid_in = 1'b0;
  logic        spawn_ready_out;
  logic [1:0]  spawn_direction_in = 2'd0;
  logic [2:0]  spawn_speed_in = 3'd0;
  logic        spawn_inversed_in = 1'b0;
  logic        hit_valid_in = 1'b0;
  logic [1:0]  hit_direction_in = 2'd0;
  logic [3:0]  slot_valid_out;
  logic [7:0]  slot_direction_out;
  logic [11:0] slot_speed_out;
  logic [3:0]  slot_inversed_out;
  logic        hit_out;
  logic        miss_out;

  int checks = 0;
  int errors = 0;
  int hit_cnt = 0;
  int miss_cnt = 0;
  int hit_base;
  int miss_base;

  arrow_scheduler dut (
    .clk               (clk),
    .rst_in            (rst_in),
    .hcount_in         (hcount_in),
    .vcount_in         (vcount_in),
    .spawn_valid_in    (spawn_valid_in),
    .spawn_ready_out   (spawn_ready_out),
    .spawn_direction_in(spawn_direction_in),
    .spawn_speed_in    (spawn_speed_in),
    .spawn_inversed_in (spawn_inversed_in),
    .hit_valid_in      (hit_valid_in),
    .hit_direction_in  (hit_direction_in),
    .slot_valid_out    (slot_valid_out),
    .slot_direction_out(slot_direction_out),
    .slot_speed_out    (slot_speed_out),
    .slot_inversed_out (slot_inversed_out),
    .hit_out           (hit_out),
    .miss_out          (miss_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    #1;
    if (hit_out === 1'b1) hit_cnt++;
    if (miss_out === 1'b1) miss_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    @(negedge clk);
    rst_in = 1'b1;
    spawn_valid_in = 1'b0;
    hit_valid_in = 1'b0;
    hcount_in = 11'd5;
    vcount_in = 10'd5;
    @(negedge clk);
    @(negedge clk);
    rst_in = 1'b0;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      @(negedge clk);
      hcount_in = 11'd0;
      vcount_in = 10'd0;
      @(negedge clk);
      hcount_in = 11'd5;
      vcount_in = 10'd5;
    end
  endtask

  task automatic spawn(input logic [1:0] d, input logic [2:0] s, input logic inv);
    @(negedge clk);
    spawn_valid_in = 1'b1;
    spawn_direction_in = d;
    spawn_speed_in = s;
    spawn_inversed_in = inv;
    @(negedge clk);
    spawn_valid_in = 1'b0;
  endtask

  task automatic press(input logic [1:0] d);
    @(negedge clk);
    hit_valid_in = 1'b1;
    hit_direction_in = d;
    @(negedge clk);
    hit_valid_in = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (slot_valid_out !== 4'b0000) begin errors++; $display("FAIL reset_valid: got %b want 0000", slot_valid_out); end
    checks++; if (spawn_ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", spawn_ready_out); end
    checks++; if (hit_out !== 1'b0 || miss_out !== 1'b0) begin errors++; $display("FAIL reset_pulses: got hit=%b miss=%b want 0 0", hit_out, miss_out); end
    checks++; if ({slot_direction_out, slot_speed_out, slot_inversed_out} !== 24'd0) begin errors++; $display("FAIL reset_payload: got %h want 000000", {slot_direction_out, slot_speed_out, slot_inversed_out}); end
  endtask

  task automatic test_spawn();
    spawn(2'd0, 3'd2, 1'b0);
    checks++; if (slot_valid_out !== 4'b0001) begin errors++; $display("FAIL spawn_valid: got %b want 0001", slot_valid_out); end
    checks++; if (spawn_ready_out !== 1'b1) begin errors++; $display("FAIL spawn_ready: got %b want 1", spawn_ready_out); end
    checks++; if (slot_direction_out[1:0] !== 2'd0 || slot_speed_out[2:0] !== 3'd2) begin errors++; $display("FAIL spawn_payload: got dir=%0d speed=%0d want 0 2", slot_direction_out[1:0], slot_speed_out[2:0]); end
  endtask

  task automatic test_hit_window();
    miss_base = miss_cnt;
    frames(100);
    press(2'd0);
    checks++; if (hit_out !== 1'b0 || slot_valid_out !== 4'b0001) begin errors++; $display("FAIL early_press: got hit=%b valid=%b want 0 0001", hit_out, slot_valid_out); end
    frames(60);
    press(2'd0);
    checks++; if (hit_out !== 1'b1 || slot_valid_out !== 4'b0000) begin errors++; $display("FAIL hit_160: got hit=%b valid=%b want 1 0000", hit_out, slot_valid_out); end
    @(negedge clk);
    checks++; if (hit_out !== 1'b0 || slot_valid_out !== 4'b0000) begin errors++; $display("FAIL hit_after: got hit=%b valid=%b want 0 0000", hit_out, slot_valid_out); end
    spawn(2'd1, 3'd3, 1'b1);
    checks++; if (slot_valid_out !== 4'b0001 || slot_direction_out[1:0] !== 2'd1 || slot_inversed_out[0] !== 1'b1) begin errors++; $display("FAIL reuse_slot0: got valid=%b dir=%0d inv=%b want 0001 1 1", slot_valid_out, slot_direction_out[1:0], slot_inversed_out[0]); end
    checks++; if (miss_cnt - miss_base !== 0) begin errors++; $display("FAIL hit_no_miss: got %0d misses want 0", miss_cnt - miss_base); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_mask;
    do_reset();
    exp_mask = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      spawn_valid_in = 1'b1;
      spawn_direction_in = 2'(i);
      spawn_speed_in = 3'(i + 1);
      if (i > 0) begin
        checks++; if (slot_valid_out !== exp_mask) begin errors++; $display("FAIL fill_%0d: got %b want %b", i, slot_valid_out, exp_mask); end
      end
      exp_mask = {exp_mask[2:0], 1'b1};
    end
    @(negedge clk);
    spawn_direction_in = 2'd1;
    spawn_speed_in = 3'd7;
    checks++; if (slot_valid_out !== 4'b1111 || spawn_ready_out !== 1'b0) begin errors++; $display("FAIL full: got valid=%b ready=%b want 1111 0", slot_valid_out, spawn_ready_out); end
    checks++; if (slot_direction_out !== 8'b11_10_01_00 || slot_speed_out[11:9] !== 3'd4) begin errors++; $display("FAIL full_payload: got dir=%b speed3=%0d want 11100100 4", slot_direction_out, slot_speed_out[11:9]); end
    repeat (3) @(negedge clk);
    checks++; if (slot_valid_out !== 4'b1111 || spawn_ready_out !== 1'b0) begin errors++; $display("FAIL stall: got valid=%b ready=%b want 1111 0", slot_valid_out, spawn_ready_out); end
    frames(160);
    press(2'd0);
    checks++; if (hit_out !== 1'b1 || slot_valid_out !== 4'b1110 || spawn_ready_out !== 1'b0) begin errors++; $display("FAIL cooldown: got hit=%b valid=%b ready=%b want 1 1110 0", hit_out, slot_valid_out, spawn_ready_out); end
    @(negedge clk);
    checks++; if (slot_valid_out !== 4'b1110 || spawn_ready_out !== 1'b1) begin errors++; $display("FAIL idle_again: got valid=%b ready=%b want 1110 1", slot_valid_out, spawn_ready_out); end
    @(negedge clk);
    spawn_valid_in = 1'b0;
    checks++; if (slot_valid_out !== 4'b1111 || slot_direction_out[1:0] !== 2'd1 || slot_speed_out[2:0] !== 3'd7) begin errors++; $display("FAIL fifth_spawn: got valid=%b dir=%0d speed=%0d want 1111 1 7", slot_valid_out, slot_direction_out[1:0], slot_speed_out[2:0]); end
  endtask

  task automatic test_horz_miss();
    do_reset();
    hit_base = hit_cnt;
    miss_base = miss_cnt;
    spawn(2'd2, 3'd5, 1'b0);
    frames(200);
    press(2'd2);
    checks++; if (hit_out !== 1'b0 || slot_valid_out !== 4'b0001) begin errors++; $display("FAIL horz_press_200: got hit=%b valid=%b want 0 0001", hit_out, slot_valid_out); end
    frames(55);
    @(negedge clk);
    checks++; if (slot_valid_out !== 4'b0001 || miss_cnt - miss_base !== 0) begin errors++; $display("FAIL horz_age255: got valid=%b misses=%0d want 0001 0", slot_valid_out, miss_cnt - miss_base); end
    frames(1);
    @(negedge clk);
    checks++; if (slot_valid_out !== 4'b0000 || miss_out !== 1'b1) begin errors++; $display("FAIL horz_expire: got valid=%b miss=%b want 0000 1", slot_valid_out, miss_out); end
    @(negedge clk);
    checks++; if (miss_out !== 1'b0) begin errors++; $display("FAIL horz_miss_width: got %b want 0", miss_out); end
    checks++; if (hit_cnt - hit_base !== 0 || miss_cnt - miss_base !== 1) begin errors++; $display("FAIL horz_counts: got hits=%0d misses=%0d want 0 1", hit_cnt - hit_base, miss_cnt - miss_base); end
  endtask

  task automatic test_oldest();
    do_reset();
    spawn(2'd1, 3'd0, 1'b0);
    frames(15);
    spawn(2'd1, 3'd1, 1'b0);
    checks++; if (slot_valid_out !== 4'b0011) begin errors++; $display("FAIL oldest_setup: got %b want 0011", slot_valid_out); end
    frames(155);
    press(2'd1);
    checks++; if (hit_out !== 1'b1 || slot_valid_out !== 4'b0010) begin errors++; $display("FAIL oldest_first: got hit=%b valid=%b want 1 0010", hit_out, slot_valid_out); end
    press(2'd1);
    checks++; if (hit_out !== 1'b1 || slot_valid_out !== 4'b0000) begin errors++; $display("FAIL oldest_second: got hit=%b valid=%b want 1 0000", hit_out, slot_valid_out); end
  endtask

  task automatic test_double_miss();
    do_reset();
    miss_base = miss_cnt;
    spawn(2'd0, 3'd2, 1'b0);
    spawn(2'd3, 3'd2, 1'b0);
    frames(179);
    @(negedge clk);
    checks++; if (slot_valid_out !== 4'b0011 || miss_cnt - miss_base !== 0) begin errors++; $display("FAIL vert_age179: got valid=%b misses=%0d want 0011 0", slot_valid_out, miss_cnt - miss_base); end
    frames(1);
    @(negedge clk);
    checks++; if (slot_valid_out !== 4'b0000 || miss_out !== 1'b1) begin errors++; $display("FAIL miss_first: got valid=%b miss=%b want 0000 1", slot_valid_out, miss_out); end
    @(negedge clk);
    checks++; if (miss_out !== 1'b1) begin errors++; $display("FAIL miss_second: got %b want 1", miss_out); end
    @(negedge clk);
    checks++; if (miss_out !== 1'b0 || miss_cnt - miss_base !== 2) begin errors++; $display("FAIL miss_total: got miss=%b count=%0d want 0 2", miss_out, miss_cnt - miss_base); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    spawn(2'd0, 3'd1, 1'b0);
    spawn(2'd0, 3'd1, 1'b0);
    spawn(2'd0, 3'd1, 1'b0);
    frames(180);
    @(negedge clk);
    checks++; if (miss_out !== 1'b1 || slot_valid_out !== 4'b0000) begin errors++; $display("FAIL triple_expire: got miss=%b valid=%b want 1 0000", miss_out, slot_valid_out); end
    rst_in = 1'b1;
    @(negedge clk);
    rst_in = 1'b0;
    checks++; if (miss_out !== 1'b0) begin errors++; $display("FAIL reset_drop_miss: got %b want 0", miss_out); end
    @(negedge clk);
    checks++; if (miss_out !== 1'b0 || spawn_ready_out !== 1'b1) begin errors++; $display("FAIL reset_pending: got miss=%b ready=%b want 0 1", miss_out, spawn_ready_out); end
    spawn(2'd1, 3'd6, 1'b1);
    spawn(2'd2, 3'd6, 1'b1);
    frames(10);
    @(negedge clk);
    checks++; if (slot_valid_out !== 4'b0011) begin errors++; $display("FAIL midflight_setup: got %b want 0011", slot_valid_out); end
    rst_in = 1'b1;
    @(negedge clk);
    rst_in = 1'b0;
    checks++; if (slot_valid_out !== 4'b0000 || slot_speed_out !== 12'd0 || slot_inversed_out !== 4'd0) begin errors++; $display("FAIL midflight_reset: got valid=%b speed=%h inv=%b want 0000 000 0000", slot_valid_out, slot_speed_out, slot_inversed_out); end
  endtask

  initial begin
    test_reset();
    test_spawn();
    test_hit_window();
    test_back_to_back();
    test_horz_miss();
    test_oldest();
    test_double_miss();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
